// File: rtl/tow_match.sv
// Tug-of-war match engine: synchronised press-edge inputs push a lit position
// across the LED field, rounds are scored and the match ends at WIN_ROUNDS.
module tow_match #(
    parameter int FIELD_W    = 9,
    parameter int WIN_ROUNDS = 3,
    parameter int SW_W       = $clog2(WIN_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               press_l,
    input  logic               press_r,
    output logic [FIELD_W-1:0] leds,
    output logic [SW_W-1:0]    score_l,
    output logic [SW_W-1:0]    score_r,
    output logic [1:0]         round_win,
    output logic [1:0]         winner,
    output logic [6:0]         hex_l,
    output logic [6:0]         hex_r
);

    localparam int                 PW       = $clog2(FIELD_W);
    localparam int                 CENTRE_I = (FIELD_W - 1) / 2;
    localparam logic [PW-1:0]      CENTRE   = PW'(CENTRE_I);
    localparam logic [PW-1:0]      MAX_POS  = PW'(FIELD_W - 1);
    localparam logic [SW_W-1:0]    WIN_CNT  = SW_W'(WIN_ROUNDS);
    localparam logic [FIELD_W-1:0] LEDS_RST = FIELD_W'(1) << CENTRE_I;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        SCORED = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit 1 carries the left player, bit 0 the right player.
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] ev;
    logic       mv_l, mv_r;

    state_t             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [SW_W-1:0]    score_l_q, score_l_d;
    logic [SW_W-1:0]    score_r_q, score_r_d;
    logic [1:0]         round_win_q, round_win_d;
    logic [1:0]         winner_q, winner_d;
    logic [FIELD_W-1:0] leds_q, leds_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Field image for a given state; DONE lights the winner's half, centre dark.
    function automatic logic [FIELD_W-1:0] field_leds(input state_t st,
                                                      input logic [PW-1:0] p,
                                                      input logic [1:0] w);
        logic [FIELD_W-1:0] f;
        f = '0;
        case (st)
            PLAY:    f = FIELD_W'(1) << p;
            SCORED:  f = '0;
            default: begin
                for (int i = 0; i < FIELD_W; i++) begin
                    f[i] = (w[1] && (i > CENTRE_I)) || (w[0] && (i < CENTRE_I));
                end
            end
        endcase
        return f;
    endfunction

    always_comb begin
        meta_d = {press_l, press_r};
        sync_d = meta_q;
        prev_d = sync_q;
    end

    assign ev   = sync_q & ~prev_q;
    assign mv_l = ev[1] & ~ev[0];
    assign mv_r = ev[0] & ~ev[1];

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        round_win_d = 2'b00;
        unique case (state_q)
            PLAY: begin
                if (mv_l) begin
                    if (pos_q != MAX_POS) begin
                        pos_d = pos_q + PW'(1);
                    end else begin
                        score_l_d   = score_l_q + SW_W'(1);
                        round_win_d = 2'b10;
                        pos_d       = CENTRE;
                        if (score_l_d == WIN_CNT) begin
                            state_d  = DONE;
                            winner_d = 2'b10;
                        end else begin
                            state_d = SCORED;
                        end
                    end
                end else if (mv_r) begin
                    if (pos_q != '0) begin
                        pos_d = pos_q - PW'(1);
                    end else begin
                        score_r_d   = score_r_q + SW_W'(1);
                        round_win_d = 2'b01;
                        pos_d       = CENTRE;
                        if (score_r_d == WIN_CNT) begin
                            state_d  = DONE;
                            winner_d = 2'b01;
                        end else begin
                            state_d = SCORED;
                        end
                    end
                end
            end
            SCORED: begin
                state_d = PLAY;
                pos_d   = CENTRE;
            end
            default: begin
            end
        endcase
        leds_d = field_leds(state_d, pos_d, winner_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q      <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            state_q     <= PLAY;
            pos_q       <= CENTRE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            round_win_q <= 2'b00;
            winner_q    <= 2'b00;
            leds_q      <= LEDS_RST;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            pos_q       <= pos_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            round_win_q <= round_win_d;
            winner_q    <= winner_d;
            leds_q      <= leds_d;
        end
    end

    assign leds      = leds_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign round_win = round_win_q;
    assign winner    = winner_q;
    assign hex_l     = seg7(4'(score_l_q));
    assign hex_r     = seg7(4'(score_r_q));

endmodule
